// File: rtl/dual_port_mem.sv
`default_nettype none
// ============================================================================
//  Module   : dual_port_mem
//  Brief    : Synchronous dual-port memory. Port A is a read-only fetch
//             port with write-first bypass from port B; port B is a
//             read/write data port with byte enables. Contents are set up
//             by a hardware clear sweep followed by a streamed preload.
//  Revision : 1.0 - initial release
// ============================================================================
module dual_port_mem #(
  parameter int DW     = 16,
  parameter int AW     = 10,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic            ld_valid,
  input  logic [AW-1:0]   ld_addr,
  input  logic [DW-1:0]   ld_data,
  input  logic            ld_done,
  input  logic            a_en,
  input  logic [AW-1:0]   a_addr,
  output logic [DW-1:0]   a_rdata,
  output logic            a_rvalid,
  input  logic            b_en,
  input  logic            b_we,
  input  logic [DW/8-1:0] b_be,
  input  logic [AW-1:0]   b_addr,
  input  logic [DW-1:0]   b_wdata,
  output logic [DW-1:0]   b_rdata,
  output logic            b_rvalid
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;
  // Last address of the clear sweep; the extra counter bit keeps the
  // terminal compare from aliasing with address 0.
  localparam logic [AW:0] CNT_LAST = {1'b0, {AW{1'b1}}};

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [AW:0] cnt_q, cnt_d;
  logic        run;

  // Single shared write port: clear, preload and port B never overlap.
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] wr_be;

  logic [DW-1:0] mem_q [DEPTH];

  // Index 0 is port A, index 1 is port B.
  logic [1:0]         rd_req;
  logic [1:0][DW-1:0] rd_word;
  logic [1:0]         s1_valid_q, s1_valid_d;
  logic [1:0][DW-1:0] s1_data_q, s1_data_d;
  logic [1:0]         out_valid;
  logic [1:0][DW-1:0] out_data;

  assign run   = (state_q == ST_RUN);
  assign ready = run;

  // Next-state logic: clear sweep, then preload until ld_done, then run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (ld_done) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // State and clear counter registers; reset restarts the clear sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Select the write source for this cycle; nothing is written under reset.
  always_comb begin
    wr_addr = cnt_q[AW-1:0];
    wr_data = '0;
    wr_be   = '0;
    if (!rst) begin
      unique case (state_q)
        ST_CLEAR: begin
          wr_addr = cnt_q[AW-1:0];
          wr_be   = '1;
        end
        ST_LOAD: begin
          if (ld_valid) begin
            wr_addr = ld_addr;
            wr_data = ld_data;
            wr_be   = '1;
          end
        end
        ST_RUN: begin
          if (b_en && b_we) begin
            wr_addr = b_addr;
            wr_data = b_wdata;
            wr_be   = b_be;
          end
        end
        default: begin
          wr_be = '0;
        end
      endcase
    end
  end

  // Storage array with per-byte write enables.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) begin
        mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Read requests and words; port A sees a same-cycle port B write merged in.
  always_comb begin
    rd_req[0]  = run && a_en;
    rd_req[1]  = run && b_en && !b_we;
    rd_word[0] = mem_q[a_addr];
    rd_word[1] = mem_q[b_addr];
    if (wr_addr == a_addr) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          rd_word[0][8*i +: 8] = wr_data[8*i +: 8];
        end
      end
    end
  end

  // First read stage: data is captured only on a request so it holds otherwise.
  always_comb begin
    s1_valid_d = rd_req;
    s1_data_d  = s1_data_q;
    for (int p = 0; p < 2; p++) begin
      if (rd_req[p]) begin
        s1_data_d[p] = rd_word[p];
      end
    end
  end

  // First read stage registers; reset drops any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= '0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [1:0]         s2_valid_q, s2_valid_d;
    logic [1:0][DW-1:0] s2_data_q, s2_data_d;

    // Output stage: forward stage-1 data only when it is valid.
    always_comb begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = s2_data_q;
      for (int p = 0; p < 2; p++) begin
        if (s1_valid_q[p]) begin
          s2_data_d[p] = s1_data_q[p];
        end
      end
    end

    // Output stage registers, no stall input.
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid_q <= '0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_data_q  <= s2_data_d;
      end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
  end else begin : g_lat1
    assign out_valid = s1_valid_q;
    assign out_data  = s1_data_q;
  end

  assign a_rvalid = out_valid[0];
  assign a_rdata  = out_data[0];
  assign b_rvalid = out_valid[1];
  assign b_rdata  = out_data[1];

endmodule
`default_nettype wire
